dmem_responder: RTL

//  Data-memory responder: the memory-side end of the core's load/store port.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_pkg
// Brief   : Shared encodings for the data-memory responder and its lane aligner.
// Rev     : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Combinational byte-lane steering for stores and lane extraction
//           with sign/zero extension for loads.
// Rev     : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [3:0]        o_lane_we,
  output logic [DATA_W-1:0] o_wdata_rep,
  output logic [DATA_W-1:0] o_rdata_ext,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rword[{i_addr_lo, 3'b000} +: 8];
    w_half      = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    o_lane_we   = 4'b0000;
    o_wdata_rep = '0;
    o_rdata_ext = '0;
    o_misalign  = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_lane_we   = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_lane_we   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{i_signed & w_half[15]}}, w_half};
        o_misalign  = i_addr_lo[0];
      end
      SIZE_W: begin
        o_lane_we   = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = i_rword;
        o_misalign  = |i_addr_lo;
      end
      // Reserved size is folded into the misalign flag so the top sees one error source.
      default: o_misalign = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Stallable memory-side slave for the core load/store port with
//           byte-banked storage, lane steering and error reporting.
// Rev     : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_we;
  logic [DATA_W-1:0]     r_addr;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_oor;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_do_write;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [3:0]            w_lane_we;
  logic [DATA_W-1:0]     w_wdata_rep;
  logic [DATA_W-1:0]     w_rdata_ext;
  logic [DATA_W-1:0]     w_rword;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_idx      = r_addr[DEPTH_LOG2+1:2];
  assign w_oor      = |r_addr[DATA_W-1:DEPTH_LOG2+2];
  assign w_err      = w_oor || w_misalign;
  // rst gates the write so a store caught in ACCESS by reset never lands.
  assign w_do_write = !rst && (r_state == ST_ACCESS) && r_we && !w_err;

  dmem_lane_align u_align (
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .i_rword     (w_rword),
    .o_lane_we   (w_lane_we),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (w_do_write && w_lane_we[g]) begin
        r_mem[w_idx] <= w_wdata_rep[8*g +: 8];
      end
    end

    assign w_rword[8*g +: 8] = r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_addr   <= req_addr;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_ACCESS) begin
      r_err   <= w_err;
      r_rdata <= (r_we || w_err) ? '0 : w_rdata_ext;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
`default_nettype wire
